mont_mul_serial: RTL

//  Parametrised word-serial Montgomery multiplier: result = a*b*2^-N mod m.

---
 rtl/mont_mul_serial.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mont_mul_serial.sv
// mont_mul_serial
//   Word-serial Montgomery multiplier: result = a * B * 2^-N mod m, where
//   B is b, a or 1 depending on mode. One W-bit word of a is consumed per
//   cycle (K = N/W iterations). A single conditional subtraction then
//   produces a fully reduced result. That subtraction adds the
//   precomputed m_n = 2^(N+2) - m and inspects the carry, so no magnitude
//   comparator is needed.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   operand bundle handshake; in_ready high only in IDLE
//   mode                00 a*b, 01 a*a, 10 a*1 (convert out), 11 as 00
//   a, b, m             operands and odd modulus (a, b < m)
//   m_n                 2^(N+2) - m on N+2 bits
//   m_prime             -m^-1 mod 2^W
//   out_valid/out_ready result handshake; result held until accepted
//   result              reduced product (< m)
//   busy                high whenever the FSM is not IDLE
module mont_mul_serial #(
    parameter int N = 3072,
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] m,
    input  logic [N+1:0] m_n,
    input  logic [W-1:0] m_prime,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         busy
);

    localparam int K  = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    generate
        if ((W < 2) || ((N % W) != 0)) begin : g_param_check
            $error("mont_mul_serial: N must be a multiple of W and W must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOOP = 2'd1,
        S_SUB  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N+1:0]    t_q, t_d;
    logic [N-1:0]    res_q, res_d;

    // Operand copies; a_q is shifted right by one word per iteration so the
    // current word is always a_q[W-1:0].
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    m_q, m_d;
    logic [N+1:0]    mn_q, mn_d;
    logic [W-1:0]    mp_q, mp_d;

    logic [N+W-1:0]  prod_ab;
    logic [N+W-1:0]  prod_qm;
    logic [W-1:0]    q_sum;
    logic [W-1:0]    q_i;
    logic [N+W+1:0]  acc;
    logic [N+1:0]    t_next;
    logic [N+2:0]    sub_s;

    // Iteration datapath. Only the low word of a_i*B is needed for q_i,
    // which equals the low word of the full product.
    assign prod_ab = {{N{1'b0}}, a_q[W-1:0]} * {{W{1'b0}}, b_q};
    assign q_sum   = t_q[W-1:0] + prod_ab[W-1:0];
    assign q_i     = q_sum * mp_q;
    assign prod_qm = {{N{1'b0}}, q_i} * {{W{1'b0}}, m_q};
    assign acc     = {{W{1'b0}}, t_q} + {2'b00, prod_ab} + {2'b00, prod_qm};
    assign t_next  = acc[N+W+1:W];

    // Final reduction: carry out of T + (2^(N+2) - m) means T >= m.
    assign sub_s   = {1'b0, t_q} + {1'b0, mn_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        mn_d    = mn_q;
        mp_d    = mp_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d  = a;
                    m_d  = m;
                    mn_d = m_n;
                    mp_d = m_prime;
                    unique case (mode)
                        2'b01:   b_d = a;
                        2'b10:   b_d = {{(N-1){1'b0}}, 1'b1};
                        default: b_d = b;
                    endcase
                    t_d     = '0;
                    cnt_d   = '0;
                    state_d = S_LOOP;
                end
            end
            S_LOOP: begin
                t_d   = t_next;
                a_d   = a_q >> W;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(K - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                res_d   = sub_s[N+2] ? sub_s[N-1:0] : t_q[N-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            t_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            res_q   <= res_d;
        end
    end

    // Operand registers carry no reset: they are only read after a load.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        m_q  <= m_d;
        mn_q <= mn_d;
        mp_q <= mp_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;

`ifndef SYNTHESIS
    // q_i is chosen so the word shifted out is zero, and T < 2m keeps the
    // reduced value below 2^N.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == S_LOOP)) begin
            assert (acc[W-1:0] == '0)
                else $error("mont_mul_serial: low word not cancelled");
        end
        if (!rst && (state_q == S_SUB) && sub_s[N+2]) begin
            assert (sub_s[N+1:N] == 2'b00)
                else $error("mont_mul_serial: T exceeded 2m");
        end
    end
`endif

endmodule
